// File: rtl/sample_mac_accum_pkg.sv
// sample_mac_accum_pkg: shared widths, FSM encoding and saturation helper for the MAC layer stages.
package sample_mac_accum_pkg;
  localparam int DIN_W = 14;
  localparam int ACC_W = 24;
  localparam int DOUT_W = 14;
  typedef enum logic {ACCUM, HOLD} state_t;
  typedef struct packed {
    logic signed [31:0] data;
    logic sat;
  } sat_t;
  function automatic sat_t saturate(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi, lo;
    sat_t r;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.sat = v > hi || v < lo;
    r.data = 32'(v > hi ? hi : v < lo ? lo : v);
    return r;
  endfunction
endpackage

// File: rtl/sample_mac_accum_if.sv
// sample_mac_accum_if: operand-issue, product and result handshake bundle of the MAC accumulator.
interface sample_mac_accum_if import sample_mac_accum_pkg::*; #(
  parameter int DIN_WIDTH = DIN_W,
  parameter int DOUT_WIDTH = DOUT_W
);
  logic ce, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic signed [DIN_WIDTH-1:0] prod, bias;
  logic signed [DOUT_WIDTH-1:0] out_data;
  modport master(output ce, in_valid, prod, bias, out_ready, input in_ready, out_valid, out_data, out_sat);
  modport slave(input ce, in_valid, prod, bias, out_ready, output in_ready, out_valid, out_data, out_sat);
endinterface

// File: rtl/sample_valid_pipe.sv
// sample_valid_pipe: ce-gated valid shift register tracking issues through a multiplier's stages.
module sample_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic din,
  output logic tail
);
  logic [DEPTH-1:0] pipe;
  always_ff @(posedge clk)
    if (!reset) pipe <= '0;
    else if (ce) pipe <= (pipe << 1) | DEPTH'(din);
  assign tail = pipe[DEPTH-1];
endmodule

// File: rtl/sample_mac_accum.sv
// sample_mac_accum: accumulates NUM_TERMS multiplier products plus bias, emits a saturated result.
module sample_mac_accum import sample_mac_accum_pkg::*; #(
  parameter int DIN_WIDTH = DIN_W,
  parameter int ACC_WIDTH = ACC_W,
  parameter int DOUT_WIDTH = DOUT_W,
  parameter int NUM_TERMS = 16,
  parameter int MUL_LATENCY = 2,
  parameter int SHIFT = 0
) (
  input logic clk,
  input logic reset,
  sample_mac_accum_if.slave bus
);
  localparam int CW = $clog2(NUM_TERMS + 1);
  state_t state, state_nx;
  logic [CW-1:0] issue_cnt, acc_cnt;
  logic signed [ACC_WIDTH-1:0] acc, acc_nx;
  logic issue, tail, step, last;
  sat_t res;
  assign bus.in_ready = reset && state == ACCUM && issue_cnt < CW'(NUM_TERMS);
  assign bus.out_valid = state == HOLD;
  assign issue = bus.in_valid && bus.in_ready && bus.ce;
  assign step = bus.ce && tail;
  assign last = step && acc_cnt == CW'(NUM_TERMS - 1);
  assign acc_nx = (acc_cnt == '0 ? ACC_WIDTH'($signed(bus.bias[DIN_WIDTH-1:0])) : acc)
                + ACC_WIDTH'($signed(bus.prod[DIN_WIDTH-1:0]));
  assign res = saturate(64'(acc_nx >>> SHIFT), DOUT_WIDTH);
  sample_valid_pipe #(.DEPTH(MUL_LATENCY)) u_pipe (
    .clk(clk), .reset(reset), .ce(bus.ce), .din(issue), .tail(tail)
  );
  always_comb begin
    state_nx = state;
    state_nx = state == ACCUM ? (last ? HOLD : ACCUM) : (bus.out_ready ? ACCUM : HOLD);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ACCUM;
      issue_cnt <= '0;
      acc_cnt <= '0;
      acc <= '0;
      bus.out_data <= '0;
      bus.out_sat <= 1'b0;
    end else begin
      state <= state_nx;
      if (step) acc <= acc_nx;
      if (last) begin
        issue_cnt <= '0;
        acc_cnt <= '0;
        bus.out_data <= DOUT_WIDTH'(res.data);
        bus.out_sat <= res.sat;
      end else begin
        if (issue) issue_cnt <= issue_cnt + 1'b1;
        if (step) acc_cnt <= acc_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sample_mac_accum.sv
// tb_sample_mac_accum: three accumulator lanes (4/16/1 terms) fed by a ce-gated multiplier model.
module tb_sample_mac_accum;
  localparam int NT[3] = '{4, 16, 1};
  localparam int SH[3] = '{0, 0, 2};
  logic clk = 1'b0, reset = 1'b0;
  logic ce[3], in_valid[3], out_ready[3], in_ready[3], out_valid[3], out_sat[3];
  logic signed [13:0] a[3], b[3], bias[3], out_data[3];
  logic signed [13:0] qa[$], qb[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : lane
    sample_mac_accum_if bus();
    logic signed [13:0] m1, m2;
    always @(posedge clk) if (ce[g]) begin m1 <= 14'(a[g] * b[g]); m2 <= m1; end
    assign bus.ce = ce[g];
    assign bus.in_valid = in_valid[g];
    assign bus.prod = m2;
    assign bus.bias = bias[g];
    assign bus.out_ready = out_ready[g];
    assign in_ready[g] = bus.in_ready;
    assign out_valid[g] = bus.out_valid;
    assign out_data[g] = bus.out_data;
    assign out_sat[g] = bus.out_sat;
    sample_mac_accum #(.NUM_TERMS(NT[g]), .SHIFT(SH[g])) dut (.clk(clk), .reset(reset), .bus(bus));
  end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic rand_ops(input int n);
    qa.delete(); qb.delete();
    for (int i = 0; i < n; i++) begin
      qa.push_back(14'(int'($urandom_range(127)) - 64));
      qb.push_back(14'(int'($urandom_range(127)) - 64));
    end
  endtask
  task automatic fixed_ops(input int n, input int av);
    qa.delete(); qb.delete();
    for (int i = 0; i < n; i++) begin qa.push_back(14'(av)); qb.push_back(14'sd1); end
  endtask
  task automatic drive_idle(input int k, input int ce_pct);
    ce[k] = $urandom_range(99) < ce_pct;
    in_valid[k] = 1'b0;
    a[k] = 14'($urandom);
    b[k] = 14'($urandom);
  endtask
  task automatic issue_ops(input int k, input int n, input int ce_pct);
    int i = 0, guard = 0;
    logic take;
    while (i < n && guard < 2000) begin
      @(negedge clk);
      ce[k] = $urandom_range(99) < ce_pct;
      in_valid[k] = 1'b1;
      a[k] = qa[i];
      b[k] = qb[i];
      take = in_ready[k] && ce[k];
      @(posedge clk);
      if (take) i++;
      guard++;
    end
    if (i < n) chk("issue_timeout", i, n);
  endtask
  task automatic finish_group(input int k, input int bv, input int ce_pct, input int hold);
    int sum = bv, lat = 0, ed, es;
    logic seen = 1'b0;
    logic signed [13:0] p;
    for (int i = 0; i < qa.size(); i++) begin p = 14'(qa[i] * qb[i]); sum += int'(p); end
    sum = sum >>> SH[k];
    ed = sum > 8191 ? 8191 : sum < -8192 ? -8192 : sum;
    es = int'(sum != ed);
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      drive_idle(k, ce_pct);
      seen = out_valid[k];
    end
    chk("out_valid_rise", int'(seen), 1);
    if (ce_pct == 100) chk("latency", lat, 3);
    chk("out_data", out_data[k], ed);
    chk("out_sat", int'(out_sat[k]), es);
    chk("in_ready_hold", int'(in_ready[k]), 0);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      ce[k] = 1'b1;
      in_valid[k] = 1'($urandom_range(1));
      chk("hold_valid", int'(out_valid[k]), 1);
      chk("hold_data", out_data[k], ed);
      chk("hold_ready", int'(in_ready[k]), 0);
    end
    @(negedge clk);
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    chk("out_valid_drop", int'(out_valid[k]), 0);
    chk("in_ready_rise", int'(in_ready[k]), 1);
  endtask
  task automatic run_group(input int k, input int bv, input int ce_pct, input int hold);
    bias[k] = 14'(bv);
    issue_ops(k, qa.size(), ce_pct);
    finish_group(k, bv, ce_pct, hold);
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      ce[k] = 0; in_valid[k] = 0; out_ready[k] = 0; a[k] = 0; b[k] = 0; bias[k] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", int'(out_valid[k]), 0);
      chk("rst_in_ready", int'(in_ready[k]), 0);
      chk("rst_out_data", out_data[k], 0);
      chk("rst_out_sat", int'(out_sat[k]), 0);
    end
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("post_rst_ready", int'(in_ready[k]), 1);
    qa = '{14'sd10, -14'sd20, 14'sd30, 14'sd40};
    qb = '{14'sd1, 14'sd1, 14'sd1, 14'sd1};
    run_group(0, 100, 100, 0);
    for (int r = 0; r < 3; r++) begin rand_ops(4); run_group(0, int'($urandom_range(16383)) - 8192, 70, 0); end
    fixed_ops(16, 8191);
    run_group(1, 0, 100, 0);
    fixed_ops(16, -8192);
    run_group(1, 0, 100, 0);
    rand_ops(16);
    run_group(1, 1234, 100, 0);
    run_group(1, 1234, 50, 0);
    rand_ops(16);
    run_group(1, -777, 100, 10);
    rand_ops(16);
    run_group(1, 55, 100, 0);
    rand_ops(16);
    bias[1] = 14'sd9;
    issue_ops(1, 7, 100);
    @(negedge clk);
    in_valid[1] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", int'(out_valid[1]), 0);
    chk("mid_rst_data", out_data[1], 0);
    chk("mid_rst_sat", int'(out_sat[1]), 0);
    chk("mid_rst_ready", int'(in_ready[1]), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_release", int'(in_ready[1]), 1);
    rand_ops(16);
    run_group(1, -300, 100, 0);
    qa = '{14'sd17}; qb = '{14'sd1};
    for (int r = 0; r < 3; r++) run_group(2, 3, 100, 0);
    qa = '{-14'sd18};
    run_group(2, -3, 100, 0);
    for (int r = 0; r < 4; r++) begin rand_ops(1); run_group(2, int'($urandom_range(16383)) - 8192, 60, 0); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sample_mac_accum.md
Name: sample_mac_accum

Overview:
- Downstream consumer of the 14-bit signed pipelined multiplier (clk/reset/ce/din0/din1/dout style, 2 register stages, ce-gated, no reset on data path).
- Tracks operand-issue validity through the multiplier latency and accumulates NUM_TERMS products plus a bias into a wide accumulator.
- Emits one saturated, rescaled 14-bit dot-product result per group over a valid/ready handshake to the next layer.

Parameters:
- DIN_WIDTH, 14, product and bias width (matches multiplier dout)
- ACC_WIDTH, 24, signed accumulator width
- DOUT_WIDTH, 14, result width
- NUM_TERMS, 16, products per result (>=1)
- MUL_LATENCY, 2, multiplier register stages between operand issue and dout
- SHIFT, 0, arithmetic right shift applied before saturation

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- ce  in  1  clock enable shared with the multiplier instance
- in_valid  in  1  operands are being presented to the multiplier this cycle
- in_ready  out  1  block accepts a new operand issue
- prod  in  DIN_WIDTH  signed multiplier dout
- bias  in  DIN_WIDTH  signed bias, sampled with the first accepted product of a group
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  DOUT_WIDTH  signed saturated result
- out_sat  out  1  result was clipped (valid with out_valid)

Behaviour:
- Reset (reset==0 at posedge): valid pipe cleared, issue_cnt=0, acc_cnt=0, acc=0, state=ACCUM; in_ready=0 during reset, 1 on the first cycle after; out_valid=0, out_data=0, out_sat=0. Products in flight are discarded.
- Issue: an issue is accepted when in_valid & in_ready & ce. issue_cnt increments on each accepted issue. in_ready = (state==ACCUM) & (issue_cnt < NUM_TERMS).
- Valid pipe: MUL_LATENCY-deep shift register; it shifts only when ce=1 and loads the accepted-issue bit. The tail bit marks prod as valid in that cycle, exactly mirroring the multiplier's ce-gated stages. With ce held high, prod is consumed MUL_LATENCY cycles after the issue.
- Accumulate, on ce & tail valid:
  - acc_cnt==0: acc = sext(bias) + sext(prod).
  - Otherwise: acc = acc + sext(prod).
  - acc_cnt increments.
  - Accumulator overflow wraps, since ACC_WIDTH must cover NUM_TERMS*2^(DIN_WIDTH-1).
- Finish: when the accumulate step takes acc_cnt to NUM_TERMS:
  - Next cycle: state=HOLD, out_valid=1.
  - out_data = saturate(final_acc >>> SHIFT) to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1].
  - out_sat = 1 if clipped.
  - acc_cnt and issue_cnt clear.
- FSM ACCUM -> HOLD:
  - In HOLD, out_data/out_sat are stable and in_ready=0.
  - HOLD -> ACCUM on out_valid & out_ready. out_valid drops the next cycle and in_ready rises the same next cycle.
- ce=0: valid pipe, counters and acc freeze; prod is ignored. The output handshake is NOT gated by ce (HOLD can complete while ce=0).
- NUM_TERMS=1: every accepted issue produces a result; issue_cnt caps at 1.
- Back-to-back groups: minimum gap between the last issue of group k and the first issue of group k+1 is MUL_LATENCY+2 cycles with out_ready held high.
- Reset asserted in HOLD: out_valid drops the following cycle and the result is lost.

Decomposition:
- Shared package: ACC_WIDTH/DIN_WIDTH/DOUT_WIDTH defaults, state encoding (ACCUM, HOLD), and a saturate-with-flag function used here and by future layer stages.
- Sub-module sample_valid_pipe: a ce-gated, synchronously cleared MUL_LATENCY-deep bit shift register. It is reusable alongside every multiplier instance.

Test Plan:
- Bias=100, NUM_TERMS=4, prods 10,-20,30,40 with ce=1 -> out_valid 1 cycle after the 4th product is consumed, out_data=160, out_sat=0.
- Bias=0, 16 products of 8191 (max positive), SHIFT=0 -> acc=131056, out_data=8191, out_sat=1. Repeat with -8192 -> out_data=-8192, out_sat=1.
- Random ce toggling (50%) during 16 issues with a golden multiplier model -> result equals the ce=1 run. Products presented while the tail bit is 0 are ignored.
- out_ready held low for 10 cycles in HOLD -> out_data stable, in_ready=0, in_valid pulses not accepted. Release -> next group starts; issue_cnt counts only post-release issues.
- Reset pulsed low after 7 of 16 issues -> all outputs zero next cycle. A following clean 16-term group gives the exact expected sum with no stale contribution.
- NUM_TERMS=1, SHIFT=2, bias=3, prod=17 -> out_data=5, results on consecutive groups with out_ready high.
